// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN lift controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } lift_state_t;

    function automatic int floor_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_tick_prescaler.sv
// Single-cycle tick every DIV enabled clocks; the count holds while ena is low.
// Combinational tick off the registered count, no derived clock.
module tick_prescaler #(
    parameter int DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (ena) begin
            if (cnt_q == LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN lift: latches calls every clk, moves/dwells on prescaled ticks.
// Outputs come straight from registered state; ena=0 freezes motion but not call latching.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 4,
    parameter int TICK_DIV     = 100000000,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    input  logic [NUM_FLOORS-1:0]             call_req,
    input  logic                              obstruct,
    output logic [floor_w(NUM_FLOORS)-1:0]    floor,
    output logic [NUM_FLOORS-1:0]             floor_onehot,
    output logic [NUM_FLOORS-1:0]             pending,
    output logic                              dir_up,
    output logic                              moving,
    output logic                              door_open,
    output logic                              busy_n
);
    localparam int FW = floor_w(NUM_FLOORS);
    localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] TRAV_LOAD = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0] TOP       = FW'(NUM_FLOORS - 1);

    lift_state_t           state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d, nf;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pend_q, clr;
    logic [TW-1:0]         trav_q, trav_d;
    logic [DW-1:0]         door_q, door_d;
    logic                  recall_q, recall_d;
    logic                  tick;

    tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .tick  (tick)
    );

    function automatic logic req_ahead(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FW-1:0] f, input logic up);
        req_ahead = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (up ? (i > int'(f)) : (i < int'(f))) req_ahead = req_ahead | p[i];
    endfunction

    function automatic logic [NUM_FLOORS-1:0] oh(input logic [FW-1:0] f);
        oh    = '0;
        oh[f] = 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        trav_d   = trav_q;
        door_d   = door_q;
        nf       = floor_q;
        clr      = '0;
        // A call at the open door is swallowed at once and only restarts the dwell.
        recall_d = (state_q == DOOR) && !tick && (recall_q || call_req[floor_q]);
        if (state_q == DOOR) clr = oh(floor_q);
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q[floor_q]) begin
                        state_d = DOOR;
                        clr     = oh(floor_q);
                        door_d  = DOOR_LOAD;
                    end else if (req_ahead(pend_q, floor_q, 1'b1) &&
                                 (dir_q || !req_ahead(pend_q, floor_q, 1'b0))) begin
                        state_d = MOVE;
                        dir_d   = 1'b1;
                        trav_d  = TRAV_LOAD;
                    end else if (req_ahead(pend_q, floor_q, 1'b0)) begin
                        state_d = MOVE;
                        dir_d   = 1'b0;
                        trav_d  = TRAV_LOAD;
                    end
                end
                MOVE: begin
                    if (trav_q != '0) begin
                        trav_d = trav_q - TW'(1);
                    end else begin
                        if (dir_q && floor_q != TOP)        nf = floor_q + FW'(1);
                        else if (!dir_q && floor_q != '0)   nf = floor_q - FW'(1);
                        floor_d = nf;
                        if (pend_q[nf]) begin
                            state_d = DOOR;
                            clr     = oh(nf);
                            door_d  = DOOR_LOAD;
                        end else if (req_ahead(pend_q, nf, dir_q)) begin
                            trav_d = TRAV_LOAD;
                        end else if (req_ahead(pend_q, nf, !dir_q)) begin
                            dir_d  = !dir_q;
                            trav_d = TRAV_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DOOR: begin
                    if (obstruct || recall_q || call_req[floor_q]) door_d = DOOR_LOAD;
                    else if (door_q != '0)                         door_d = door_q - DW'(1);
                    else                                           state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            pend_q   <= '0;
            trav_q   <= '0;
            door_q   <= '0;
            recall_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            pend_q   <= (pend_q | call_req) & ~clr;
            trav_q   <= trav_d;
            door_q   <= door_d;
            recall_q <= recall_d;
        end
    end

    assign floor        = floor_q;
    assign floor_onehot = oh(floor_q);
    assign pending      = pend_q;
    assign dir_up       = dir_q;
    assign moving       = (state_q == MOVE);
    assign door_open    = (state_q == DOOR);
    assign busy_n       = (state_q == IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for the SCAN lift: expected stop floors are queued as calls are issued.
module tb_elevator_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, obstruct, ena8;
    logic [3:0] call_req;
    logic [7:0] call8;
    logic [1:0] floor;
    logic [3:0] onehot, pending;
    logic       dir_up, moving, door_open, busy_n;
    logic [2:0] floor8;
    logic [7:0] onehot8, pending8;
    logic       dir8, moving8, door8, busy8;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    elevator_scan_ctrl #(.NUM_FLOORS(4), .TICK_DIV(2), .TRAVEL_TICKS(2), .DOOR_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .call_req(call_req), .obstruct(obstruct),
        .floor(floor), .floor_onehot(onehot), .pending(pending), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .busy_n(busy_n)
    );

    elevator_scan_ctrl #(.NUM_FLOORS(8), .TICK_DIV(2), .TRAVEL_TICKS(2), .DOOR_TICKS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .call_req(call8), .obstruct(1'b0),
        .floor(floor8), .floor_onehot(onehot8), .pending(pending8), .dir_up(dir8),
        .moving(moving8), .door_open(door8), .busy_n(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] mask);
        call_req = mask;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic wait_moving(input string tag);
        int t = 0;
        while (moving !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk(tag, moving, 1);
    endtask

    task automatic wait_floor(input string tag, input int f);
        int t = 0;
        while (floor !== f[1:0] && t < 300) begin @(negedge clk); t++; end
        chk(tag, floor, f);
    endtask

    task automatic wait_stop(input string tag);
        int t = 0;
        int e;
        while (door_open !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        while (door_open !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        chk({tag, "_door"}, door_open, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_floor"}, floor, e);
            chk({tag, "_onehot"}, onehot, 1 << e);
        end
    endtask

    task automatic wait_closed(input string tag, input int exp_open);
        int n = 0;
        while (door_open === 1'b1 && n < 400) begin n++; @(negedge clk); end
        chk(tag, n, exp_open);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, mx;
        rst_n = 1'b0; ena = 1'b1; ena8 = 1'b1; obstruct = 1'b0;
        call_req = '0; call8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset/idle state, then asynchronous reset mid-MOVE
        repeat (20) @(negedge clk);
        chk("idle_floor", floor, 0);
        chk("idle_pending", pending, 0);
        chk("idle_busy_n", busy_n, 1);
        chk("idle_door", door_open, 0);
        chk("idle_moving", moving, 0);
        chk("idle_dir", dir_up, 1);
        pulse(4'b1000);
        wait_floor("rst_reach1", 1);
        rst_n = 1'b0;
        #1;
        chk("rst_floor", floor, 0);
        chk("rst_moving", moving, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy_n", busy_n, 1);
        chk("rst_onehot", onehot, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_resume", moving, 0);

        // 2: single call to the top floor
        pulse(4'b1000);
        chk("t2_latch", pending, 4'b1000);
        exp_q.push_back(3);
        wait_moving("t2_moving");
        wait_floor("t2_f1", 1);
        n = 0;
        while (floor === 2'd1 && n < 50) begin @(negedge clk); n++; end
        chk("t2_step_clks", n, 4);
        wait_stop("t2_stop");
        chk("t2_pending", pending, 0);
        wait_closed("t2_dwell", 6);
        chk("t2_idle_busy", busy_n, 1);

        // 3: SCAN order 1,2,3 then return to 0
        pulse(4'b0001);
        exp_q.push_back(0);
        wait_stop("t3_home");
        wait_closed("t3_home_dwell", 6);
        pulse(4'b1010);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        wait_moving("t3_moving");
        pulse(4'b0100);
        wait_stop("t3_s1");
        chk("t3_s1_pending", pending, 4'b1100);
        chk("t3_s1_dir", dir_up, 1);
        wait_stop("t3_s2");
        chk("t3_s2_dir", dir_up, 1);
        wait_stop("t3_s3");
        chk("t3_s3_dir", dir_up, 1);
        wait_closed("t3_s3_dwell", 6);
        pulse(4'b0001);
        exp_q.push_back(0);
        wait_moving("t3_back_moving");
        chk("t3_back_dir", dir_up, 0);
        wait_stop("t3_back");
        wait_closed("t3_back_dwell", 6);

        // 4: at floor 2 heading up, calls 0 and 3 together
        pulse(4'b0100);
        exp_q.push_back(2);
        wait_stop("t4_to2");
        chk("t4_to2_dir", dir_up, 1);
        wait_closed("t4_to2_dwell", 6);
        pulse(4'b1001);
        exp_q.push_back(3); exp_q.push_back(0);
        wait_stop("t4_first");
        wait_closed("t4_first_dwell", 6);
        wait_stop("t4_second");
        chk("t4_second_dir", dir_up, 0);
        wait_closed("t4_second_dwell", 6);

        // 5: obstruction hold, then a recall at the open door
        pulse(4'b0001);
        exp_q.push_back(0);
        wait_stop("t5_open");
        obstruct = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (door_open !== 1'b1) bad++;
        end
        obstruct = 1'b0;
        chk("t5_hold_closed_samples", bad, 0);
        wait_closed("t5_release_dwell", 6);
        pulse(4'b0001);
        exp_q.push_back(0);
        wait_stop("t5_reopen");
        repeat (2) @(negedge clk);
        pulse(4'b0001);
        chk("t5_recall_pending", pending, 0);
        wait_closed("t5_recall_dwell", 7);
        chk("t5_after_pending", pending, 0);
        chk("t5_after_busy", busy_n, 1);

        // 6: freeze with ena=0 mid-travel
        pulse(4'b1000);
        exp_q.push_back(3); exp_q.push_back(0);
        wait_floor("t6_f1", 1);
        ena = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 2) call_req = 4'b0001;
            if (i == 3) call_req = 4'b0000;
            @(negedge clk);
            if (floor !== 2'd1 || moving !== 1'b1) bad++;
        end
        chk("t6_frozen_bad", bad, 0);
        chk("t6_frozen_pending", pending, 4'b1001);
        ena = 1'b1;
        n = 0;
        while (floor === 2'd1 && n < 50) begin @(negedge clk); n++; end
        chk("t6_resume_clks", n, 4);
        wait_stop("t6_top");
        wait_closed("t6_top_dwell", 6);
        wait_stop("t6_ground");
        wait_closed("t6_ground_dwell", 6);

        // 6b: eight floors, call at the top
        call8 = 8'h80;
        @(negedge clk);
        call8 = '0;
        chk("t8_latch", pending8, 8'h80);
        n = 0; mx = 0;
        while (door8 !== 1'b1 && n < 300) begin
            @(negedge clk); n++;
            if (int'(floor8) > mx) mx = int'(floor8);
        end
        chk("t8_door", door8, 1);
        chk("t8_floor", floor8, 7);
        chk("t8_onehot", onehot8, 8'h80);
        chk("t8_pending", pending8, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (int'(floor8) > mx) mx = int'(floor8);
        end
        chk("t8_max_floor", mx, 7);
        chk("t8_idle", busy8, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
